// File: rtl/fft_pkg.sv
// Shared definitions for the FFT-bin producer and the peak-frequency analyser.
package fft_pkg;

  localparam int unsigned N_BINS = 16;
  localparam int unsigned BIN_W  = 32;

  typedef logic [BIN_W-1:0] bin_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_PULSE,
    O_WAIT
  } rd_state_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft_bin_bank.sv
// One 16-bin frame store: single write port, every bin visible on a flat read bus.
module fft_bin_bank
  import fft_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [3:0]                addr,
  input  bin_t                      wdata,
  output logic [N_BINS*BIN_W-1:0]   rdata
);

  logic [N_BINS*BIN_W-1:0] regs;

  // bin storage, cleared on reset, one bin written per enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (we) begin
      regs[addr*BIN_W +: BIN_W] <= wdata;
    end
  end

  assign rdata = regs;

endmodule

// File: rtl/fft_bin_collector.sv
// Collects serial FFT bins into double-buffered natural-order frames for the analyser.
module fft_bin_collector
  import fft_pkg::*;
#(
  parameter int unsigned N_BINS      = 16,
  parameter int unsigned BIN_W       = 32,
  parameter int unsigned BIT_REVERSE = 1,
  parameter int unsigned DONE_TMO    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sop,
  input  logic [BIN_W-1:0] in_data,
  input  logic             ana_done,
  output logic             fft_valid,
  output logic [BIN_W-1:0] fft_d0,
  output logic [BIN_W-1:0] fft_d1,
  output logic [BIN_W-1:0] fft_d2,
  output logic [BIN_W-1:0] fft_d3,
  output logic [BIN_W-1:0] fft_d4,
  output logic [BIN_W-1:0] fft_d5,
  output logic [BIN_W-1:0] fft_d6,
  output logic [BIN_W-1:0] fft_d7,
  output logic [BIN_W-1:0] fft_d8,
  output logic [BIN_W-1:0] fft_d9,
  output logic [BIN_W-1:0] fft_d10,
  output logic [BIN_W-1:0] fft_d11,
  output logic [BIN_W-1:0] fft_d12,
  output logic [BIN_W-1:0] fft_d13,
  output logic [BIN_W-1:0] fft_d14,
  output logic [BIN_W-1:0] fft_d15,
  output logic             frame_err,
  output logic             tmo_err,
  output logic [7:0]       frame_cnt
);

  localparam logic [3:0] LAST  = 4'(N_BINS - 1);
  localparam int unsigned TMO_W = $clog2(DONE_TMO + 1);

  logic [3:0]               wcnt, wcnt_nx, waddr;
  logic                     wbank, rbank;
  logic [1:0]               full, full_nx;
  logic                     accept, we, set_full, release_rd, ferr_nx;
  logic [TMO_W-1:0]         timer;
  rd_state_t                state, state_nx;
  logic [N_BINS*BIN_W-1:0]  rd0, rd1, rsel;

  assign in_ready = !full[wbank];
  assign accept   = in_valid & in_ready;

  // write-side decode: sop protocol checks, slot selection, frame completion
  always_comb begin
    we       = 1'b0;
    waddr    = '0;
    wcnt_nx  = wcnt;
    set_full = 1'b0;
    ferr_nx  = 1'b0;
    if (accept) begin
      if (wcnt == '0 && !in_sop) begin
        ferr_nx = 1'b1;
      end else if (wcnt != '0 && in_sop) begin
        we      = 1'b1;
        waddr   = '0;
        wcnt_nx = 4'd1;
        ferr_nx = 1'b1;
      end else begin
        we    = 1'b1;
        waddr = (BIT_REVERSE != 0) ? bitrev4(wcnt) : wcnt;
        if (wcnt == LAST) begin
          wcnt_nx  = '0;
          set_full = 1'b1;
        end else begin
          wcnt_nx = wcnt + 4'd1;
        end
      end
    end
  end

  // read-side next state; release frees the presented bank
  always_comb begin
    state_nx   = state;
    release_rd = 1'b0;
    case (state)
      O_IDLE:  if (full[rbank]) state_nx = O_PULSE;
      O_PULSE: state_nx = O_WAIT;
      O_WAIT: begin
        if (ana_done || timer == TMO_W'(DONE_TMO)) begin
          state_nx   = O_IDLE;
          release_rd = 1'b1;
        end
      end
      default: state_nx = O_IDLE;
    endcase
  end

  // filling bank and read bank are always different, so set and clear never collide
  always_comb begin
    full_nx = full;
    if (set_full)   full_nx[wbank] = 1'b1;
    if (release_rd) full_nx[rbank] = 1'b0;
  end

  // collector state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      full      <= '0;
      frame_err <= 1'b0;
      state     <= O_IDLE;
      fft_valid <= 1'b0;
      timer     <= '0;
      frame_cnt <= '0;
    end else begin
      wcnt      <= wcnt_nx;
      wbank     <= wbank ^ set_full;
      rbank     <= rbank ^ release_rd;
      full      <= full_nx;
      frame_err <= ferr_nx;
      state     <= state_nx;
      fft_valid <= (state_nx == O_PULSE);
      if (state == O_PULSE) begin
        timer     <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (state == O_WAIT) begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign tmo_err = (state == O_WAIT) && (timer == TMO_W'(DONE_TMO));

  fft_bin_bank u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we & ~wbank),
    .addr  (waddr),
    .wdata (in_data),
    .rdata (rd0)
  );

  fft_bin_bank u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we & wbank),
    .addr  (waddr),
    .wdata (in_data),
    .rdata (rd1)
  );

  assign rsel    = rbank ? rd1 : rd0;
  assign fft_d0  = rsel[ 0*BIN_W +: BIN_W];
  assign fft_d1  = rsel[ 1*BIN_W +: BIN_W];
  assign fft_d2  = rsel[ 2*BIN_W +: BIN_W];
  assign fft_d3  = rsel[ 3*BIN_W +: BIN_W];
  assign fft_d4  = rsel[ 4*BIN_W +: BIN_W];
  assign fft_d5  = rsel[ 5*BIN_W +: BIN_W];
  assign fft_d6  = rsel[ 6*BIN_W +: BIN_W];
  assign fft_d7  = rsel[ 7*BIN_W +: BIN_W];
  assign fft_d8  = rsel[ 8*BIN_W +: BIN_W];
  assign fft_d9  = rsel[ 9*BIN_W +: BIN_W];
  assign fft_d10 = rsel[10*BIN_W +: BIN_W];
  assign fft_d11 = rsel[11*BIN_W +: BIN_W];
  assign fft_d12 = rsel[12*BIN_W +: BIN_W];
  assign fft_d13 = rsel[13*BIN_W +: BIN_W];
  assign fft_d14 = rsel[14*BIN_W +: BIN_W];
  assign fft_d15 = rsel[15*BIN_W +: BIN_W];

endmodule

// File: tb/tb_fft_bin_collector.sv
// Directed bench: a natural-order and a bit-reversed collector share one stimulus stream.
module tb_fft_bin_collector;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sop, ana_done;
  logic [31:0] in_data;
  logic        auto_en, pv;

  logic        rdy_n, fv_n, fe_n, te_n;
  logic        rdy_r, fv_r, fe_r, te_r;
  logic [7:0]  fc_n, fc_r;
  logic [31:0] dn [16];
  logic [31:0] dr [16];

  int unsigned n_pass = 0, n_checks = 0;

  int unsigned cyc = 0, vcnt = 0, ferr_cnt = 0, tmo_cnt = 0, stall_cnt = 0;
  int unsigned last_v = 0, tmo_gap = 0;
  int unsigned vq [$];
  logic [31:0] snap_n [16];
  logic [31:0] snap_r [16];

  int unsigned v0, s0, f0, f1, t0;

  always #5 clk = ~clk;

  fft_bin_collector #(.N_BINS(16), .BIN_W(32), .BIT_REVERSE(0), .DONE_TMO(15)) u_nat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_n), .in_sop(in_sop),
    .in_data(in_data), .ana_done(ana_done), .fft_valid(fv_n),
    .fft_d0(dn[0]), .fft_d1(dn[1]), .fft_d2(dn[2]), .fft_d3(dn[3]),
    .fft_d4(dn[4]), .fft_d5(dn[5]), .fft_d6(dn[6]), .fft_d7(dn[7]),
    .fft_d8(dn[8]), .fft_d9(dn[9]), .fft_d10(dn[10]), .fft_d11(dn[11]),
    .fft_d12(dn[12]), .fft_d13(dn[13]), .fft_d14(dn[14]), .fft_d15(dn[15]),
    .frame_err(fe_n), .tmo_err(te_n), .frame_cnt(fc_n)
  );

  fft_bin_collector #(.N_BINS(16), .BIN_W(32), .BIT_REVERSE(1), .DONE_TMO(15)) u_rev (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r), .in_sop(in_sop),
    .in_data(in_data), .ana_done(ana_done), .fft_valid(fv_r),
    .fft_d0(dr[0]), .fft_d1(dr[1]), .fft_d2(dr[2]), .fft_d3(dr[3]),
    .fft_d4(dr[4]), .fft_d5(dr[5]), .fft_d6(dr[6]), .fft_d7(dr[7]),
    .fft_d8(dr[8]), .fft_d9(dr[9]), .fft_d10(dr[10]), .fft_d11(dr[11]),
    .fft_d12(dr[12]), .fft_d13(dr[13]), .fft_d14(dr[14]), .fft_d15(dr[15]),
    .frame_err(fe_r), .tmo_err(te_r), .frame_cnt(fc_r)
  );

  // event monitor on the natural-order instance, snapshots both at each frame strobe
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fv_n) begin
      vcnt   <= vcnt + 1;
      last_v <= cyc;
      vq.push_back(cyc);
      for (int unsigned k = 0; k < 16; k++) begin
        snap_n[k] <= dn[k];
        snap_r[k] <= dr[k];
      end
    end
    if (fe_n) ferr_cnt <= ferr_cnt + 1;
    if (te_n) begin
      tmo_cnt <= tmo_cnt + 1;
      tmo_gap <= cyc - last_v;
    end
    if (in_valid && !rdy_n) stall_cnt <= stall_cnt + 1;
  end

  // analyser model: done one cycle after the frame strobe when enabled
  initial begin
    ana_done = 1'b0;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      ana_done = auto_en && pv;
      pv = fv_n;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic sop, input logic [31:0] d);
    int unsigned b = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d;
    while (!rdy_n && b < 200) begin
      tick();
      b++;
    end
    if (b >= 200) check("send_ready_bound", {31'b0, rdy_n}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned b = 0;
    while (vcnt < target && b < budget) begin
      tick();
      b++;
    end
    check(tag, vcnt, target);
  endtask

  initial begin
    auto_en  = 1'b1;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = '0;
    tick();
    tick();
    check("rst_valid", {31'b0, fv_n}, 32'd0);
    check("rst_ready", {31'b0, rdy_n}, 32'd1);
    check("rst_cnt", {24'b0, fc_n}, 32'd0);
    check("rst_d0", dn[0], 32'd0);
    check("rst_d15", dr[15], 32'd0);
    check("rst_ferr", {31'b0, fe_n}, 32'd0);
    check("rst_tmo", {31'b0, te_n}, 32'd0);
    rst = 1'b0;
    tick();

    // natural-order frame
    v0 = vcnt; s0 = stall_cnt;
    for (int unsigned k = 0; k < 16; k++) send(k == 0, 32'h0001_0000 * k);
    wait_valid("t1_wait", v0 + 1, 10);
    repeat (6) tick();
    check("t1_pulses", vcnt, v0 + 1);
    check("t1_nat_d5", snap_n[5], 32'h0005_0000);
    check("t1_rev_d5", snap_r[5], 32'h000A_0000);
    check("t1_cnt", {24'b0, fc_n}, 32'd1);
    check("t1_stalls", stall_cnt - s0, 32'd0);

    // bit-reversed frame, input count i carries i
    v0 = vcnt;
    for (int unsigned k = 0; k < 16; k++) send(k == 0, k);
    wait_valid("t2_wait", v0 + 1, 10);
    repeat (4) tick();
    check("t2_rev_d8", snap_r[8], 32'd1);
    check("t2_rev_d12", snap_r[12], 32'd3);
    check("t2_rev_d15", snap_r[15], 32'd15);
    check("t2_nat_d8", snap_n[8], 32'd8);
    check("t2_cnt", {24'b0, fc_r}, 32'd2);

    // four back-to-back frames
    v0 = vcnt; s0 = stall_cnt; f0 = ferr_cnt;
    for (int unsigned f = 0; f < 4; f++)
      for (int unsigned k = 0; k < 16; k++) send(k == 0, 32'h3000_0000 | (f << 8) | k);
    wait_valid("t3_wait", v0 + 4, 40);
    repeat (4) tick();
    check("t3_gap1", vq[v0 + 1] - vq[v0], 32'd16);
    check("t3_gap2", vq[v0 + 2] - vq[v0 + 1], 32'd16);
    check("t3_gap3", vq[v0 + 3] - vq[v0 + 2], 32'd16);
    check("t3_stalls", stall_cnt - s0, 32'd0);
    check("t3_cnt", {24'b0, fc_n}, 32'd6);
    check("t3_last_d7", snap_n[7], 32'h3000_0307);
    check("t3_ferr", ferr_cnt - f0, 32'd0);

    // analyser silent: timeouts release frames, third frame back-pressured
    auto_en = 1'b0;
    v0 = vcnt; s0 = stall_cnt; t0 = tmo_cnt;
    for (int unsigned f = 0; f < 3; f++)
      for (int unsigned k = 0; k < 16; k++) send(k == 0, 32'h4000_0000 | (f << 8) | k);
    wait_valid("t4_wait", v0 + 3, 60);
    check("t4_tmo_cnt", tmo_cnt - t0, 32'd2);
    check("t4_tmo_gap", tmo_gap, 32'd16);
    check("t4_stalls", stall_cnt - s0, 32'd2);
    check("t4_f3_d0", snap_n[0], 32'h4000_0200);
    check("t4_f3_d15", snap_n[15], 32'h4000_020F);
    repeat (20) tick();
    check("t4_tmo_cnt3", tmo_cnt - t0, 32'd3);
    check("t4_cnt", {24'b0, fc_n}, 32'd9);
    auto_en = 1'b1;

    // sop mid-frame restarts the frame
    v0 = vcnt; f0 = ferr_cnt;
    for (int unsigned k = 0; k < 7; k++) send(k == 0, 32'hDEAD_0000 + k);
    for (int unsigned k = 0; k < 16; k++) send(k == 0, 32'h5000_0000 + k);
    wait_valid("t5_wait", v0 + 1, 10);
    repeat (4) tick();
    check("t5_ferr", ferr_cnt - f0, 32'd1);
    check("t5_pulses", vcnt, v0 + 1);
    for (int unsigned k = 0; k < 16; k++) check("t5_bin", snap_n[k], 32'h5000_0000 + k);

    // bin without sop at frame start is dropped
    f1 = ferr_cnt;
    send(1'b0, 32'hBAD0_0001);
    repeat (3) tick();
    check("t5_drop_ferr", ferr_cnt - f1, 32'd1);
    for (int unsigned k = 0; k < 16; k++) send(k == 0, 32'h6000_0000 + k);
    wait_valid("t5b_wait", v0 + 2, 10);
    repeat (4) tick();
    check("t5b_d0", snap_n[0], 32'h6000_0000);
    check("t5b_d15", snap_n[15], 32'h6000_000F);
    check("t5b_ferr", ferr_cnt - f1, 32'd1);

    // reset mid-fill
    v0 = vcnt; f0 = ferr_cnt; t0 = tmo_cnt;
    for (int unsigned k = 0; k < 9; k++) send(k == 0, 32'h7000_0000 + k);
    #2 rst = 1'b1;
    #1;
    check("t6a_d0", dn[0], 32'd0);
    check("t6a_d15", dn[15], 32'd0);
    check("t6a_cnt", {24'b0, fc_n}, 32'd0);
    check("t6a_ready", {31'b0, rdy_n}, 32'd1);
    rst = 1'b0;
    tick();

    // reset while waiting for the analyser
    auto_en = 1'b0;
    for (int unsigned k = 0; k < 16; k++) send(k == 0, 32'h8000_0000 + k);
    wait_valid("t6b_wait", v0 + 1, 10);
    repeat (3) tick();
    check("t6b_held_d3", dn[3], 32'h8000_0003);
    #2 rst = 1'b1;
    #1;
    check("t6b_d3", dn[3], 32'd0);
    check("t6b_valid", {31'b0, fv_n}, 32'd0);
    check("t6b_tmo", {31'b0, te_n}, 32'd0);
    check("t6b_cnt", {24'b0, fc_n}, 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("t6b_no_repeat", vcnt, v0 + 1);
    check("t6b_no_tmo", tmo_cnt - t0, 32'd0);
    auto_en = 1'b1;

    for (int unsigned k = 0; k < 16; k++) send(k == 0, 32'h9000_0000 + k);
    wait_valid("t6c_wait", v0 + 2, 10);
    repeat (4) tick();
    check("t6c_d9", snap_n[9], 32'h9000_0009);
    check("t6c_rev_d9", snap_r[9], 32'h9000_0009);
    check("t6c_cnt", {24'b0, fc_n}, 32'd1);
    check("t6c_ferr", ferr_cnt - f0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
